// File: rtl/bresenham_pkg.sv
// Shared types and constants for the Bresenham line controller and its edge mux.
// Vertex fields are packed little-end first: x0, y0, x1, y1, x2, y2.
package bresenham_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_WAIT,
        ST_DONE,
        ST_DONE_WAIT
    } bla_state_t;

    localparam int COORD_W = 8;
    localparam int VERT_W  = 6 * COORD_W;

    localparam int X0_LSB = 0;
    localparam int Y0_LSB = 8;
    localparam int X1_LSB = 16;
    localparam int Y1_LSB = 24;
    localparam int X2_LSB = 32;
    localparam int Y2_LSB = 40;

endpackage

// File: rtl/bresenham_edge_select.sv
// Combinational mux picking the two endpoints of the current polygon edge
// from the latched vertex list. The unused edge code 3 yields all zeros.
module bresenham_edge_select
    import bresenham_pkg::*;
(
    input  logic [VERT_W-1:0]  vertices,
    input  logic [1:0]         edge_idx,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1
);

    logic [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;

    assign vx0 = vertices[X0_LSB +: COORD_W];
    assign vy0 = vertices[Y0_LSB +: COORD_W];
    assign vx1 = vertices[X1_LSB +: COORD_W];
    assign vy1 = vertices[Y1_LSB +: COORD_W];
    assign vx2 = vertices[X2_LSB +: COORD_W];
    assign vy2 = vertices[Y2_LSB +: COORD_W];

    // Edge 0 = v0->v1, edge 1 = v1->v2, edge 2 closes the triangle v2->v0.
    always_comb begin
        x0 = '0;
        y0 = '0;
        x1 = '0;
        y1 = '0;
        case (edge_idx)
            2'd0: begin x0 = vx0; y0 = vy0; x1 = vx1; y1 = vy1; end
            2'd1: begin x0 = vx1; y0 = vy1; x1 = vx2; y1 = vy2; end
            2'd2: begin x0 = vx2; y0 = vy2; x1 = vx0; y1 = vy0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/bresenham_line_controller.sv
// Sequencing FSM that walks the edges of a line or triangle, handing each edge
// to the line drawer and pulsing bla_done once the whole shape is finished.
module bresenham_line_controller
    import bresenham_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               bla_en,
    input  logic               vertice_num,
    input  logic [VERT_W-1:0]  coordinates,
    input  logic               draw_done,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic               draw_en,
    output logic               bla_done
);

    bla_state_t         state, next_state;
    logic [1:0]         edge_idx;
    logic [VERT_W-1:0]  verts;
    logic               tri_mode;
    logic               last_edge;
    logic [COORD_W-1:0] sel_x0, sel_y0, sel_x1, sel_y1;

    assign last_edge = !tri_mode || (edge_idx == 2'd2);

    // Despite its name, n_rst is an active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state    <= ST_IDLE;
            edge_idx <= 2'd0;
            verts    <= '0;
            tri_mode <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && bla_en) begin
                verts    <= coordinates;
                tri_mode <= vertice_num;
                edge_idx <= 2'd0;
            end else if (state == ST_WAIT && !last_edge) begin
                edge_idx <= edge_idx + 2'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (bla_en) next_state = ST_DRAW;
            ST_DRAW:      if (draw_done) next_state = ST_WAIT;
            ST_WAIT:      next_state = last_edge ? ST_DONE : ST_DRAW;
            ST_DONE:      next_state = ST_DONE_WAIT;
            ST_DONE_WAIT: next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    bresenham_edge_select u_edge_select (
        .vertices (verts),
        .edge_idx (edge_idx),
        .x0       (sel_x0),
        .y0       (sel_y0),
        .x1       (sel_x1),
        .y1       (sel_y1)
    );

    // Endpoints are only meaningful while the drawer is enabled; zero otherwise.
    always_comb begin
        draw_en  = (state == ST_DRAW);
        bla_done = (state == ST_DONE);
        x0       = draw_en ? sel_x0 : '0;
        y0       = draw_en ? sel_y0 : '0;
        x1       = draw_en ? sel_x1 : '0;
        y1       = draw_en ? sel_y1 : '0;
    end

endmodule

// File: tb/tb_bresenham_line_controller.sv
// Directed testbench for bresenham_line_controller; inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
module tb_bresenham_line_controller;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        bla_en;
    logic        vertice_num;
    logic [47:0] coordinates;
    logic        draw_done;
    logic [7:0]  x0, y0, x1, y1;
    logic        draw_en;
    logic        bla_done;

    int checks = 0;
    int errors = 0;

    // {draw_en, bla_done, x0, y0, x1, y1}
    logic [33:0] obs;
    assign obs = {draw_en, bla_done, x0, y0, x1, y1};

    localparam logic [33:0] IDLE_OUT = 34'h0;
    localparam logic [33:0] DONE_OUT = {2'b01, 32'h0};

    always #5 clk = ~clk;

    bresenham_line_controller dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .bla_en      (bla_en),
        .vertice_num (vertice_num),
        .coordinates (coordinates),
        .draw_done   (draw_done),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .draw_en     (draw_en),
        .bla_done    (bla_done)
    );

    task automatic test_reset();
        n_rst = 1'b1;
        bla_en = 1'b1;
        vertice_num = 1'b1;
        coordinates = 48'hFFFF_FFFF_FFFF;
        draw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== IDLE_OUT) begin
                errors++;
                $display("[TB] FAIL reset_hold[%0d]: got %h expected %h", i, obs, IDLE_OUT);
            end
        end
        n_rst = 1'b0;
        bla_en = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL reset_release_idle: got %h expected %h", obs, IDLE_OUT);
        end
    endtask

    task automatic test_line_start();
        vertice_num = 1'b0;
        coordinates = 48'h5555_FFFF_0000;
        bla_en = 1'b1;
        @(negedge clk);
        bla_en = 1'b0;
        checks++;
        if (obs !== {2'b10, 32'h00_00_FF_FF}) begin
            errors++;
            $display("[TB] FAIL line_start: got %h expected %h", obs, {2'b10, 32'h00_00_FF_FF});
        end
        @(negedge clk);
        checks++;
        if (obs !== {2'b10, 32'h00_00_FF_FF}) begin
            errors++;
            $display("[TB] FAIL line_draw_hold: got %h expected %h", obs, {2'b10, 32'h00_00_FF_FF});
        end
    endtask

    task automatic test_line_completion();
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL line_wait: got %h expected %h", obs, IDLE_OUT);
        end
        @(negedge clk);
        checks++;
        if (obs !== DONE_OUT) begin
            errors++;
            $display("[TB] FAIL line_done: got %h expected %h", obs, DONE_OUT);
        end
        @(negedge clk);
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL line_done_wait: got %h expected %h", obs, IDLE_OUT);
        end
        @(negedge clk);
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL line_idle: got %h expected %h", obs, IDLE_OUT);
        end
    endtask

    task automatic test_triangle();
        logic [31:0] exp_edge [3];
        exp_edge[0] = 32'h05_0A_10_15;
        exp_edge[1] = 32'h10_15_20_30;
        exp_edge[2] = 32'h20_30_05_0A;
        vertice_num = 1'b1;
        coordinates = 48'h3020_1510_0A05;
        bla_en = 1'b1;
        @(negedge clk);
        bla_en = 1'b0;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (obs !== {2'b10, exp_edge[e]}) begin
                errors++;
                $display("[TB] FAIL tri_edge%0d: got %h expected %h", e, obs, {2'b10, exp_edge[e]});
            end
            @(negedge clk);
            checks++;
            if (obs !== {2'b10, exp_edge[e]}) begin
                errors++;
                $display("[TB] FAIL tri_edge%0d_hold: got %h expected %h", e, obs, {2'b10, exp_edge[e]});
            end
            draw_done = 1'b1;
            @(negedge clk);
            draw_done = 1'b0;
            checks++;
            if (obs !== IDLE_OUT) begin
                errors++;
                $display("[TB] FAIL tri_wait%0d: got %h expected %h", e, obs, IDLE_OUT);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== DONE_OUT) begin
            errors++;
            $display("[TB] FAIL tri_done: got %h expected %h", obs, DONE_OUT);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== IDLE_OUT) begin
                errors++;
                $display("[TB] FAIL tri_after_done[%0d]: got %h expected %h", i, obs, IDLE_OUT);
            end
        end
    endtask

    task automatic test_stability();
        draw_done = 1'b1;
        bla_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== IDLE_OUT) begin
                errors++;
                $display("[TB] FAIL idle_ignores_done[%0d]: got %h expected %h", i, obs, IDLE_OUT);
            end
        end
        draw_done = 1'b0;
        vertice_num = 1'b0;
        coordinates = 48'h0000_C3A5_7E01;
        bla_en = 1'b1;
        @(negedge clk);
        bla_en = 1'b0;
        coordinates = 48'hFFFF_FFFF_FFFF;
        vertice_num = 1'b1;
        checks++;
        if (obs !== {2'b10, 32'h01_7E_A5_C3}) begin
            errors++;
            $display("[TB] FAIL stab_start: got %h expected %h", obs, {2'b10, 32'h01_7E_A5_C3});
        end
        @(negedge clk);
        checks++;
        if (obs !== {2'b10, 32'h01_7E_A5_C3}) begin
            errors++;
            $display("[TB] FAIL stab_latched: got %h expected %h", obs, {2'b10, 32'h01_7E_A5_C3});
        end
        // draw_done stays high through WAIT/DONE; latched line mode must finish.
        draw_done = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL stab_wait: got %h expected %h", obs, IDLE_OUT);
        end
        @(negedge clk);
        checks++;
        if (obs !== DONE_OUT) begin
            errors++;
            $display("[TB] FAIL stab_done_line_mode: got %h expected %h", obs, DONE_OUT);
        end
        @(negedge clk);
        @(negedge clk);
        draw_done = 1'b0;
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL stab_idle: got %h expected %h", obs, IDLE_OUT);
        end
    endtask

    task automatic test_held_done();
        logic [31:0] exp_edge [3];
        exp_edge[0] = 32'h05_0A_10_15;
        exp_edge[1] = 32'h10_15_20_30;
        exp_edge[2] = 32'h20_30_05_0A;
        vertice_num = 1'b1;
        coordinates = 48'h3020_1510_0A05;
        bla_en = 1'b1;
        draw_done = 1'b1;
        @(negedge clk);
        bla_en = 1'b0;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (obs !== {2'b10, exp_edge[e]}) begin
                errors++;
                $display("[TB] FAIL held_edge%0d: got %h expected %h", e, obs, {2'b10, exp_edge[e]});
            end
            @(negedge clk);
            checks++;
            if (obs !== IDLE_OUT) begin
                errors++;
                $display("[TB] FAIL held_wait%0d: got %h expected %h", e, obs, IDLE_OUT);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== DONE_OUT) begin
            errors++;
            $display("[TB] FAIL held_done: got %h expected %h", obs, DONE_OUT);
        end
        draw_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL held_idle: got %h expected %h", obs, IDLE_OUT);
        end
    endtask

    task automatic test_mid_reset();
        vertice_num = 1'b1;
        coordinates = 48'h3020_1510_0A05;
        bla_en = 1'b1;
        @(negedge clk);
        bla_en = 1'b0;
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== {2'b10, 32'h10_15_20_30}) begin
            errors++;
            $display("[TB] FAIL midrst_edge1: got %h expected %h", obs, {2'b10, 32'h10_15_20_30});
        end
        n_rst = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        checks++;
        if (obs !== IDLE_OUT) begin
            errors++;
            $display("[TB] FAIL midrst_idle: got %h expected %h", obs, IDLE_OUT);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== IDLE_OUT) begin
                errors++;
                $display("[TB] FAIL midrst_no_done[%0d]: got %h expected %h", i, obs, IDLE_OUT);
            end
        end
        bla_en = 1'b1;
        @(negedge clk);
        bla_en = 1'b0;
        checks++;
        if (obs !== {2'b10, 32'h05_0A_10_15}) begin
            errors++;
            $display("[TB] FAIL midrst_restart: got %h expected %h", obs, {2'b10, 32'h05_0A_10_15});
        end
        n_rst = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_start();
        test_line_completion();
        test_triangle();
        test_stability();
        test_held_done();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
